scan_controller: RTL and testbench

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/scan_controller.sv | 118 +++++++++++
 tb/tb_scan_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_controller.sv
// Three-digit display scanner: time-multiplexes digit enables with an all-off
// blanking gap between digits, optional leading-zero suppression and a frame pulse.
module scan_controller #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       lzs,
  input  logic [3:0] cnt2,
  input  logic [3:0] cnt3,
  output logic [1:0] sw,
  output logic [2:0] an,
  output logic       frame
);

  localparam int unsigned MAX_CNT = (DIV > BLANK + 1) ? DIV : BLANK + 1;
  localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic          HAS_GAP   = (BLANK > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    sw_d;
  logic [2:0]    an_d;
  logic          frame_d;
  logic [1:0]    sw_next;

  // Active-low enable for a digit, or all-off when leading-zero suppression blanks it.
  function automatic logic [2:0] digit_an(input logic [1:0] d, input logic lz,
                                          input logic [3:0] c2, input logic [3:0] c3);
    logic supp;
    supp = lz && (((d == 2'd2) && (c3 == 4'd0)) ||
                  ((d == 2'd1) && (c3 == 4'd0) && (c2 == 4'd0)));
    if (supp || (d == 2'd3)) return 3'b111;
    return ~(3'b001 << d);
  endfunction

  assign sw_next = (sw == 2'd2) ? 2'd0 : sw + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sw    <= 2'd0;
      an    <= 3'b111;
      frame <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sw    <= sw_d;
      an    <= an_d;
      frame <= frame_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sw_d    = sw;
    an_d    = 3'b111;
    frame_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sw_d    = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_d = SHOW;
          cnt_d   = '0;
          sw_d    = 2'd0;
          an_d    = digit_an(2'd0, lzs, cnt2, cnt3);
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            // Select changes only here so the mux settles while the display is dark.
            cnt_d   = '0;
            sw_d    = sw_next;
            frame_d = (sw == 2'd2);
            if (HAS_GAP) begin
              state_d = GAP;
            end else begin
              state_d = SHOW;
              an_d    = digit_an(sw_next, lzs, cnt2, cnt3);
            end
          end else begin
            cnt_d = cnt + CW'(1);
            an_d  = digit_an(sw, lzs, cnt2, cnt3);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
            an_d    = digit_an(sw, lzs, cnt2, cnt3);
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sw_d    = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller: one instance with a blanking gap, one without,
// both checked every cycle against a timeline model of the scan.
module tb_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n, en, lzs;
  logic [3:0] cnt2, cnt3;
  logic [1:0] sw_a, sw_b;
  logic [2:0] an_a, an_b;
  logic       frame_a, frame_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scan_controller #(.DIV(4), .BLANK(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .lzs(lzs), .cnt2(cnt2), .cnt3(cnt3),
    .sw(sw_a), .an(an_a), .frame(frame_a));

  scan_controller #(.DIV(4), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .lzs(lzs), .cnt2(cnt2), .cnt3(cnt3),
    .sw(sw_b), .an(an_b), .frame(frame_b));

  // Expected {sw, an, frame} at cycle t since scan start, from the digit timeline.
  function automatic logic [5:0] model_out(input int t, input int dv, input int bl,
                                           input bit act, input logic lz,
                                           input logic [3:0] c2, input logic [3:0] c3);
    int p, digit, pos;
    logic [1:0] s;
    logic [2:0] a;
    logic f;
    if (!act) return {2'b00, 3'b111, 1'b0};
    p     = dv + bl;
    digit = (t / p) % 3;
    pos   = t % p;
    a     = 3'b111;
    if (pos < dv) begin
      s = 2'(digit);
      if (!(lz && ((digit == 2 && c3 == 0) || (digit == 1 && c3 == 0 && c2 == 0))))
        a[digit] = 1'b0;
    end else begin
      s = 2'((digit + 1) % 3);
    end
    f = (t >= dv) && (((t - dv) % (3 * p)) == 2 * p);
    return {s, a, f};
  endfunction

  bit act = 0;
  int t = 0;
  logic [5:0] exp_a = {2'b00, 3'b111, 1'b0};
  logic [5:0] exp_b = {2'b00, 3'b111, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 0;
      t   = 0;
    end else if (!en) begin
      act = 0;
      t   = 0;
    end else if (!act) begin
      act = 1;
      t   = 0;
    end else begin
      t = t + 1;
    end
    exp_a = model_out(t, 4, 2, act, lzs, cnt2, cnt3);
    exp_b = model_out(t, 4, 0, act, lzs, cnt2, cnt3);
  end

  task automatic chk(input string name, input int act_v, input int req_v);
    n_cmp++;
    if (act_v != req_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act_v, req_v);
    end
  endtask

  always @(negedge clk) begin
    chk("a_sw", sw_a, exp_a[5:4]);
    chk("a_an", an_a, exp_a[3:1]);
    chk("a_frame", frame_a, exp_a[0]);
    chk("b_sw", sw_b, exp_b[5:4]);
    chk("b_an", an_b, exp_b[3:1]);
    chk("b_frame", frame_b, exp_b[0]);
    chk("a_one_lit", int'($countones(~an_a) <= 1), 1);
    chk("b_one_lit", int'($countones(~an_b) <= 1), 1);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_scan();
    en = 1'b0;
    run(2);
    en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [2:0] lit_an_a [18];
  logic [1:0] lit_sw_a [18];
  logic [2:0] lit_an_b;

  initial begin
    for (int i = 0; i < 18; i++) begin
      lit_an_a[i] = (i < 4) ? 3'b110 : (i < 6) ? 3'b111 : (i < 10) ? 3'b101 :
                    (i < 12) ? 3'b111 : (i < 16) ? 3'b011 : 3'b111;
      lit_sw_a[i] = (i < 4) ? 2'd0 : (i < 10) ? 2'd1 : (i < 16) ? 2'd2 : 2'd0;
    end
    rst_n = 1'b1; en = 1'b0; lzs = 1'b0; cnt2 = 4'd0; cnt3 = 4'd0;
    #1 rst_n = 1'b0;
    run(3);
    chk("rst_an", an_a, 3'b111);
    chk("rst_sw", sw_a, 2'd0);
    chk("rst_frame", frame_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // First full scan pinned against hand-derived waveforms.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("lit_a_an", an_a, lit_an_a[i]);
      chk("lit_a_sw", sw_a, lit_sw_a[i]);
      chk("lit_a_frame", frame_a, (i == 16) ? 1 : 0);
      lit_an_b = (i < 4 || (i >= 12 && i < 16)) ? 3'b110 : (i < 8 || i >= 16) ? 3'b101 : 3'b011;
      chk("lit_b_an", an_b, lit_an_b);
      chk("lit_b_frame", frame_b, (i == 12) ? 1 : 0);
    end
    run(10);

    // Leading zeros on both upper digits.
    lzs = 1'b1;
    start_scan();
    run(7);
    chk("lzs00_d1", an_a, 3'b111);
    run(6);
    chk("lzs00_d2", an_a, 3'b111);
    run(30);

    // Only top digit zero, then it becomes nonzero mid-display.
    cnt2 = 4'd5;
    start_scan();
    run(8);
    chk("lzs05_d1", an_a, 3'b101);
    run(6);
    chk("lzs05_d2", an_a, 3'b111);
    cnt3 = 4'd7;
    @(negedge clk);
    chk("lzs75_d2", an_a, 3'b011);
    run(20);

    // Enable drop during the digit-1 display.
    lzs = 1'b0;
    start_scan();
    run(8);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_an", an_a, 3'b111);
    chk("endrop_sw", sw_a, 2'd0);
    chk("endrop_frame", frame_a, 0);
    run(2);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("restart_an", an_a, 3'b110);
    end
    run(20);

    // Asynchronous reset between edges during the gap.
    start_scan();
    run(5);
    chk("pregap_sw", sw_a, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an_a", an_a, 3'b111);
    chk("async_sw_a", sw_a, 2'd0);
    chk("async_an_b", an_b, 3'b111);
    chk("async_sw_b", sw_b, 2'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Varying digit values under suppression.
    lzs = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cnt2 = 4'((k * 3) % 4);
      cnt3 = 4'((k % 3 == 0) ? 0 : k);
      lzs  = (k != 5);
      run(5);
    end
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
